dmem_responder: RTL and testbench

Data-memory responder serving the CPU's load/store port. Accepts one request at a time over a valid/ready handshake, performs byte/half/word reads and writes against an internal byte-lane RAM after a configurable number of wait states, and returns the result over a second valid/ready handshake. Sits between the CPU's memory stage and on-chip data RAM. It also lets the core be exercised against non-zero memory latency.

---
 rtl/dmem_pkg.sv | 69 ++++++
 rtl/dmem_byte_ram.sv | 25 ++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Lanes are little-endian: byte lane k holds address offset k within a word.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam int LANES = 4;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~off[0];
      SIZE_W:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SIZE_B:  m = 4'b0001 << off;
      SIZE_H:  m = off[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate LSB-aligned store data so any enabled lane sees the right bits.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SIZE_B:  d = {4{wdata[7:0]}};
      SIZE_H:  d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] off,
                                              input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  r = {{24{~uns & b[7]}}, b};
      SIZE_H:  r = {{16{~uns & h[15]}}, h};
      SIZE_W:  r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// The read register only updates on an enabled access, so it holds between accesses.
module dmem_byte_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, WAIT_STATES extra cycles of latency,
// RAM access on the edge entering RESP, response held until the CPU takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_DATA_WIDTH = 32,
  parameter int WAIT_STATES     = 1
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]                 req_size,
  input  logic                       req_unsigned,
  input  logic [DMEM_DATA_WIDTH-1:0] req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DMEM_DATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_err
);

  localparam int WORD_AW = DMEM_ADDR_WIDTH - 2;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; the sender holds its payload until then and the receiver never queues.
  state_t                     state, state_nx;
  logic [3:0]                 cnt, cnt_nx;
  logic                       lat_we;
  logic [DMEM_ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]                 lat_size;
  logic                       lat_uns;
  logic [31:0]                lat_wdata;
  logic                       err_q;

  logic                       accept, commit, rsp_fire;
  logic                       acc_we;
  logic [DMEM_ADDR_WIDTH-1:0] acc_addr;
  logic [1:0]                 acc_size;
  logic [31:0]                acc_wdata;
  logic                       acc_ok;
  logic                       ram_en;
  logic [3:0]                 ram_be;
  logic [31:0]                ram_rdata;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign commit    = (state_nx == ST_RESP) && (state != ST_RESP);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_nx = ST_RESP;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // With zero wait states the access happens on the accept edge itself, so the
  // RAM must see the live request rather than the latch.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_size  = req_size;
      acc_wdata = req_wdata[31:0];
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_size  = lat_size;
      acc_wdata = lat_wdata;
    end
  end

  assign acc_ok = is_aligned(acc_size, acc_addr[1:0]);
  assign ram_en = commit && acc_ok;
  assign ram_be = acc_we ? lane_mask(acc_size, acc_addr[1:0]) : 4'b0000;

  dmem_byte_ram #(
    .ADDR_WIDTH(WORD_AW)
  ) u_ram (
    .clk  (sysclk),
    .en   (ram_en),
    .be   (ram_be),
    .addr (acc_addr[DMEM_ADDR_WIDTH-1:2]),
    .wdata(store_data(acc_size, acc_wdata)),
    .rdata(ram_rdata)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_wdata <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_size  <= req_size;
        lat_uns   <= req_unsigned;
        lat_wdata <= req_wdata[31:0];
      end
      if (commit) err_q <= ~acc_ok;
      else if (rsp_fire) err_q <= 1'b0;
    end
  end

  // Built only from registers (state, latch, RAM read register), never from req_*.
  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid && !err_q && !lat_we) begin
      rsp_rdata = DMEM_DATA_WIDTH'(load_extend(lat_size, lat_addr[1:0], lat_uns, ram_rdata));
    end
  end

  assign rsp_err = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) driven in turn,
// directed vector table, backpressure and reset sequences, then random traffic vs a byte model.
module tb_dmem_responder;
  localparam int ND = 3;

  logic        sysclk;
  logic        rst          [ND];
  logic        req_valid    [ND];
  logic        req_ready    [ND];
  logic        req_we       [ND];
  logic [11:0] req_addr     [ND];
  logic [1:0]  req_size     [ND];
  logic        req_unsigned [ND];
  logic [31:0] req_wdata    [ND];
  logic        rsp_valid    [ND];
  logic        rsp_ready    [ND];
  logic [31:0] rsp_rdata    [ND];
  logic        rsp_err      [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_responder #(
      .DMEM_ADDR_WIDTH(12),
      .DMEM_DATA_WIDTH(32),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .sysclk      (sysclk),
      .rst         (rst[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_we      (req_we[g]),
      .req_addr    (req_addr[g]),
      .req_size    (req_size[g]),
      .req_unsigned(req_unsigned[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .rsp_err     (rsp_err[g])
    );
  end

  // ---------------- clock / reset ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];            // {err, rdata}
  logic [7:0]  mdl [ND][4096];      // byte-addressed reference memory

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [15];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d (ws=%0d): got %h expected %h at %0t", name, d, ws_of(d), act, exp, $time);
    end
  endtask

  // Little-endian byte memory; result computed from the access rules directly.
  task automatic model_access(input int d, input logic we, input logic [11:0] addr,
                              input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                              output logic [32:0] exp);
    int n;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    if (n == 0 || (int'(addr) % n) != 0) begin
      exp = {1'b1, 32'h0};
    end else if (we) begin
      for (int i = 0; i < n; i++) mdl[d][int'(addr) + i] = wdata[8*i +: 8];
      exp = {1'b0, 32'h0};
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mdl[d][int'(addr) + i]) << (8*i));
      if (!uns && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      exp = {1'b0, v};
    end
  endtask

  // ---------------- driver ----------------
  // Runs one transaction; bp > 0 holds rsp_ready low for bp cycles while
  // injecting a stray store that must be ignored.
  task automatic txn(input int d, input logic we, input logic [11:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata, input int bp);
    int          k;
    logic [31:0] rd;
    logic        er;
    logic [32:0] exp;
    @(negedge sysclk);
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_addr[d]     = addr;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_wdata[d]    = wdata;
    rsp_ready[d]    = (bp == 0);
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin
      @(negedge sysclk);
      k++;
    end
    chk(d, "accept_ready", 32'(req_ready[d]), 32'd1);
    @(posedge sysclk);
    @(negedge sysclk);
    req_valid[d] = 1'b0;
    k = 1;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      @(negedge sysclk);
      k++;
    end
    chk(d, "latency", 32'(k), 32'(ws_of(d) + 1));
    rd = rsp_rdata[d];
    er = rsp_err[d];
    if (exp_q.size() == 0) begin
      chk(d, "exp_q_empty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      chk(d, "rdata", rd, exp[31:0]);
      chk(d, "err", 32'(er), 32'(exp[32]));
    end
    for (int i = 0; i < bp; i++) begin
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = {addr[11:2], 2'b00};
      req_size[d]  = 2'b10;
      req_wdata[d] = 32'hBAD0_0000 | 32'(i);
      @(posedge sysclk);
      @(negedge sysclk);
      chk(d, "hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk(d, "hold_rdata", rsp_rdata[d], rd);
      chk(d, "hold_err", 32'(rsp_err[d]), 32'(er));
      chk(d, "hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    chk(d, "post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk(d, "post_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic check_reset_outputs(input int d);
    chk(d, "rst_req_ready", 32'(req_ready[d]), 32'd1);
    chk(d, "rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk(d, "rst_rsp_rdata", rsp_rdata[d], 32'h0);
    chk(d, "rst_rsp_err", 32'(rsp_err[d]), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [32:0] e;
    logic [11:0] a;
    logic [1:0]  sz;
    logic        w, u;
    logic [31:0] wd;

    tbl[0]  = '{1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 12'h013, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[3]  = '{1'b0, 12'h013, 2'b00, 1'b1, 32'h0,        32'h000000DE, 1'b0};
    tbl[4]  = '{1'b0, 12'h012, 2'b01, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{1'b1, 12'h011, 2'b00, 1'b0, 32'h00000055, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0};
    tbl[7]  = '{1'b1, 12'h011, 2'b01, 1'b0, 32'h0000AAAA, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0};
    tbl[9]  = '{1'b0, 12'h010, 2'b11, 1'b0, 32'h0,        32'h00000000, 1'b1};
    tbl[10] = '{1'b0, 12'h010, 2'b01, 1'b1, 32'h0,        32'h000055EF, 1'b0};
    tbl[11] = '{1'b0, 12'h012, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1};
    tbl[12] = '{1'b1, 12'h010, 2'b11, 1'b0, 32'h11223344, 32'h00000000, 1'b1};
    tbl[13] = '{1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0};
    tbl[14] = '{1'b0, 12'h011, 2'b00, 1'b0, 32'h0,        32'h00000055, 1'b0};

    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d] = 1'b0;
      req_addr[d] = 12'h0;
      req_size[d] = 2'b00;
      req_unsigned[d] = 1'b0;
      req_wdata[d] = 32'h0;
      rsp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge sysclk);
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
    @(negedge sysclk);
    for (int d = 0; d < ND; d++) check_reset_outputs(d);

    for (int d = 0; d < ND; d++) begin
      // Give every word in the working window a known value.
      for (int i = 0; i < 64; i++) begin
        wd = $urandom;
        model_access(d, 1'b1, 12'(i * 4), 2'b10, 1'b0, wd, e);
        exp_q.push_back(e);
        txn(d, 1'b1, 12'(i * 4), 2'b10, 1'b0, wd, 0);
      end

      for (int i = 0; i < 15; i++) begin
        model_access(d, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, e);
        exp_q.push_back({tbl[i].exp_err, tbl[i].exp_rdata});
        txn(d, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, 0);
      end

      // Backpressure: response held 5 cycles, stray stores ignored.
      exp_q.push_back({1'b0, 32'hDEAD55EF});
      txn(d, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 5);
      exp_q.push_back({1'b0, 32'hDEAD55EF});
      txn(d, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 0);

      // Reset during the wait of a store: store dropped, outputs cleared at once.
      if (ws_of(d) > 0) begin
        model_access(d, 1'b1, 12'h020, 2'b10, 1'b0, 32'hCAFEF00D, e);
        exp_q.push_back(e);
        txn(d, 1'b1, 12'h020, 2'b10, 1'b0, 32'hCAFEF00D, 0);
        @(negedge sysclk);
        req_valid[d] = 1'b1;
        req_we[d] = 1'b1;
        req_addr[d] = 12'h020;
        req_size[d] = 2'b10;
        req_wdata[d] = 32'h12345678;
        @(posedge sysclk);
        @(negedge sysclk);
        req_valid[d] = 1'b0;
        chk(d, "wait_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk(d, "wait_req_ready", 32'(req_ready[d]), 32'd0);
        rst[d] = 1'b1;
        #1;
        check_reset_outputs(d);
        @(negedge sysclk);
        rst[d] = 1'b0;
        exp_q.push_back({1'b0, 32'hCAFEF00D});
        txn(d, 1'b0, 12'h020, 2'b10, 1'b0, 32'h0, 0);
      end

      // Random traffic inside the initialised window.
      for (int i = 0; i < 40; i++) begin
        w  = 1'($urandom_range(0, 1));
        a  = 12'($urandom_range(0, 255));
        sz = 2'($urandom_range(0, 3));
        u  = 1'($urandom_range(0, 1));
        wd = $urandom;
        model_access(d, w, a, sz, u, wd, e);
        exp_q.push_back(e);
        txn(d, w, a, sz, u, wd, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end

    chk(0, "exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
